// File: rtl/keccak_result_checker.sv
// Keccak-800 result checker: re-associates returned hashes with their nonces, compares
// against the target and queues golden nonces. Optional counters: KECCAK_CHECK_STATS_EN.
module keccak_result_checker #(
    parameter int unsigned NONCE_W   = 32,
    parameter int unsigned TAG_DEPTH = 64,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [NONCE_W-1:0] issue_nonce,
    input  logic               hash_valid,
    input  logic [255:0]       hash_in,
    input  logic [63:0]        target,
    output logic               gold_valid,
    input  logic               gold_ready,
    output logic [NONCE_W-1:0] gold_nonce,
    output logic [63:0]        gold_hash_hi,
    output logic               err_tag_overflow,
    output logic               err_tag_underflow,
    output logic               err_gold_drop,
    output logic [31:0]        hash_count,
    output logic [31:0]        gold_count
);

    localparam int unsigned TAW = $clog2(TAG_DEPTH);
    localparam int unsigned OAW = $clog2(OUT_DEPTH);
    localparam int unsigned OW  = NONCE_W + 64;

    // Tag queue
    logic [TAW:0]         tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
    logic [NONCE_W-1:0]   tag_mem_q [TAG_DEPTH];
    logic                 tag_empty, tag_full, tag_push, tag_pop;

    // Compare stage
    logic                 cmp_gold_q, cmp_gold_d;
    logic [NONCE_W-1:0]   cmp_nonce_q, cmp_nonce_d;
    logic [63:0]          cmp_hi_q, cmp_hi_d;
    logic                 golden;

    // Golden-nonce FIFO
    logic [OAW:0]         out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    logic [OW-1:0]        out_mem_q [OUT_DEPTH];
    logic [OW-1:0]        out_head;
    logic                 out_empty, out_full, out_push, out_pop;

    logic                 err_ovf_q, err_ovf_d, err_unf_q, err_unf_d, err_drop_q, err_drop_d;

    logic                 unused_hash_lo;
    assign unused_hash_lo = ^hash_in[191:0];

    always_comb begin
        tag_empty = (tag_wptr_q == tag_rptr_q);
        tag_full  = (tag_wptr_q[TAW] != tag_rptr_q[TAW]) &&
                    (tag_wptr_q[TAW-1:0] == tag_rptr_q[TAW-1:0]);
        tag_pop   = hash_valid && !tag_empty;
        // A full queue still accepts a push when the same cycle frees a slot.
        tag_push  = issue_valid && (!tag_full || tag_pop);
        golden    = (hash_in[255:192] < target);

        tag_wptr_d = tag_push ? tag_wptr_q + (TAW+1)'(1) : tag_wptr_q;
        tag_rptr_d = tag_pop  ? tag_rptr_q + (TAW+1)'(1) : tag_rptr_q;

        cmp_gold_d  = tag_pop && golden;
        cmp_nonce_d = tag_pop ? tag_mem_q[tag_rptr_q[TAW-1:0]] : cmp_nonce_q;
        cmp_hi_d    = tag_pop ? hash_in[255:192] : cmp_hi_q;

        out_empty = (out_wptr_q == out_rptr_q);
        out_full  = (out_wptr_q[OAW] != out_rptr_q[OAW]) &&
                    (out_wptr_q[OAW-1:0] == out_rptr_q[OAW-1:0]);
        out_pop   = !out_empty && gold_ready;
        out_push  = cmp_gold_q && (!out_full || out_pop);

        out_wptr_d = out_push ? out_wptr_q + (OAW+1)'(1) : out_wptr_q;
        out_rptr_d = out_pop  ? out_rptr_q + (OAW+1)'(1) : out_rptr_q;

        err_ovf_d  = err_ovf_q  || (issue_valid && tag_full && !tag_pop);
        err_unf_d  = err_unf_q  || (hash_valid && tag_empty);
        err_drop_d = err_drop_q || (cmp_gold_q && out_full && !out_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wptr_q  <= '0;
            tag_rptr_q  <= '0;
            cmp_gold_q  <= 1'b0;
            cmp_nonce_q <= '0;
            cmp_hi_q    <= '0;
            out_wptr_q  <= '0;
            out_rptr_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            tag_wptr_q  <= tag_wptr_d;
            tag_rptr_q  <= tag_rptr_d;
            cmp_gold_q  <= cmp_gold_d;
            cmp_nonce_q <= cmp_nonce_d;
            cmp_hi_q    <= cmp_hi_d;
            out_wptr_q  <= out_wptr_d;
            out_rptr_q  <= out_rptr_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
            err_drop_q  <= err_drop_d;
        end
    end

    // Storage arrays need no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem_q[tag_wptr_q[TAW-1:0]] <= issue_nonce;
        end
        if (out_push) begin
            out_mem_q[out_wptr_q[OAW-1:0]] <= {cmp_nonce_q, cmp_hi_q};
        end
    end

    // Head data is masked while empty so outputs read 0 out of reset.
    always_comb begin
        out_head     = out_empty ? '0 : out_mem_q[out_rptr_q[OAW-1:0]];
        gold_valid   = !out_empty;
        gold_nonce   = out_head[OW-1:64];
        gold_hash_hi = out_head[63:0];
    end

    assign err_tag_overflow  = err_ovf_q;
    assign err_tag_underflow = err_unf_q;
    assign err_gold_drop     = err_drop_q;

`ifdef KECCAK_CHECK_STATS_EN
    logic [31:0] hash_count_q, hash_count_d, gold_count_q, gold_count_d;

    always_comb begin
        hash_count_d = tag_pop    ? hash_count_q + 32'd1 : hash_count_q;
        gold_count_d = cmp_gold_d ? gold_count_q + 32'd1 : gold_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hash_count_q <= '0;
            gold_count_q <= '0;
        end else begin
            hash_count_q <= hash_count_d;
            gold_count_q <= gold_count_d;
        end
    end

    assign hash_count = hash_count_q;
    assign gold_count = gold_count_q;
`else
    assign hash_count = '0;
    assign gold_count = '0;
`endif

endmodule

// File: tb/tb_keccak_result_checker.sv
// Directed self-checking bench for keccak_result_checker (table of compare vectors plus
// hand-written association, backpressure, tag-full, underflow and reset sequences).
module tb_keccak_result_checker;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         issue_valid = 1'b0;
    logic [31:0]  issue_nonce = '0;
    logic         hash_valid = 1'b0;
    logic [255:0] hash_in = '0;
    logic [63:0]  target = '0;
    logic         gold_valid;
    logic         gold_ready = 1'b0;
    logic [31:0]  gold_nonce;
    logic [63:0]  gold_hash_hi;
    logic         err_tag_overflow, err_tag_underflow, err_gold_drop;
    logic [31:0]  hash_count, gold_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_hash_cnt = '0;
    logic [31:0] exp_gold_cnt = '0;

    keccak_result_checker #(.NONCE_W(32), .TAG_DEPTH(64), .OUT_DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .issue_valid       (issue_valid),
        .issue_nonce       (issue_nonce),
        .hash_valid        (hash_valid),
        .hash_in           (hash_in),
        .target            (target),
        .gold_valid        (gold_valid),
        .gold_ready        (gold_ready),
        .gold_nonce        (gold_nonce),
        .gold_hash_hi      (gold_hash_hi),
        .err_tag_overflow  (err_tag_overflow),
        .err_tag_underflow (err_tag_underflow),
        .err_gold_drop     (err_gold_drop),
        .hash_count        (hash_count),
        .gold_count        (gold_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] tgt;
        logic        gold;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] n);
        issue_valid = 1'b1;
        issue_nonce = n;
        tick();
        issue_valid = 1'b0;
    endtask

    // Drives one hasher write; the counter model advances only when a tag is expected.
    task automatic send_hash(input logic [63:0] hi, input logic [63:0] tgt, input bit exp_pop);
        hash_valid = 1'b1;
        hash_in    = {hi, {6{32'hA5A5_5A5A}}};
        target     = tgt;
        tick();
        hash_valid = 1'b0;
        if (exp_pop) begin
            exp_hash_cnt++;
            if (hi < tgt) exp_gold_cnt++;
        end
    endtask

    task automatic check_counts(input string name);
`ifdef KECCAK_CHECK_STATS_EN
        check({name, "_hash_count"}, 64'(hash_count), 64'(exp_hash_cnt));
        check({name, "_gold_count"}, 64'(gold_count), 64'(exp_gold_cnt));
`else
        check({name, "_hash_count"}, 64'(hash_count), 64'd0);
        check({name, "_gold_count"}, 64'(gold_count), 64'd0);
`endif
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{64'h100, 64'h100, 1'b0};
        vecs[1] = '{64'hFF, 64'h100, 1'b1};
        vecs[2] = '{64'h0, 64'h0, 1'b0};
        vecs[3] = '{64'h0, 64'h1, 1'b1};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1};

        // Reset state
        #12;
        check("rst_gold_valid", 64'(gold_valid), 64'd0);
        check("rst_gold_nonce", 64'(gold_nonce), 64'd0);
        check("rst_gold_hash_hi", gold_hash_hi, 64'd0);
        check("rst_flags", {61'd0, err_tag_overflow, err_tag_underflow, err_gold_drop}, 64'd0);
        check_counts("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Underflow: would-be golden hash with nothing queued
        send_hash(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        tick();
        tick();
        check("unf_flag", 64'(err_tag_underflow), 64'd1);
        check("unf_no_gold", 64'(gold_valid), 64'd0);
        check_counts("unf");

        // Nonce association with a 26-cycle hasher latency
        issue(32'h10);
        issue(32'h11);
        issue(32'h12);
        repeat (23) tick();
        send_hash(64'hFFFF_FFFF_FFFF_FFFF, 64'h100, 1'b1);
        send_hash(64'h5, 64'h100, 1'b1);
        check("assoc_lat1_not_valid", 64'(gold_valid), 64'd0);
        send_hash(64'hFFFF_FFFF_FFFF_FFFF, 64'h100, 1'b1);
        check("assoc_lat2_valid", 64'(gold_valid), 64'd1);
        check("assoc_nonce", 64'(gold_nonce), 64'h11);
        check("assoc_hash_hi", gold_hash_hi, 64'h5);
        tick();
        gold_ready = 1'b1;
        tick();
        gold_ready = 1'b0;
        check("assoc_single_entry", 64'(gold_valid), 64'd0);
        check_counts("assoc");

        // Compare vectors
        for (int i = 0; i < 8; i++) begin
            issue(32'h20 + 32'(i));
            send_hash(vecs[i].hi, vecs[i].tgt, 1'b1);
            tick();
            check($sformatf("vec%0d_golden", i), 64'(gold_valid), 64'(vecs[i].gold));
            if (vecs[i].gold) begin
                check($sformatf("vec%0d_nonce", i), 64'(gold_nonce), 64'h20 + 64'(i));
                check($sformatf("vec%0d_hash_hi", i), gold_hash_hi, vecs[i].hi);
                gold_ready = 1'b1;
                tick();
                gold_ready = 1'b0;
            end
            check($sformatf("vec%0d_empty_after", i), 64'(gold_valid), 64'd0);
        end
        check_counts("vecs");

        // Backpressure: five golden results into a four-entry FIFO
        for (int i = 0; i < 5; i++) issue(32'h40 + 32'(i));
        for (int i = 0; i < 5; i++) send_hash(64'(i), 64'h100, 1'b1);
        check("bp_no_drop_yet", 64'(err_gold_drop), 64'd0);
        tick();
        check("bp_drop_flag", 64'(err_gold_drop), 64'd1);
        check("bp_valid", 64'(gold_valid), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_drain%0d_nonce", k), 64'(gold_nonce), 64'h40 + 64'(k));
            check($sformatf("bp_drain%0d_hash_hi", k), gold_hash_hi, 64'(k));
            gold_ready = 1'b1;
            tick();
        end
        gold_ready = 1'b0;
        check("bp_drained", 64'(gold_valid), 64'd0);
        check_counts("bp");

        // Tag queue full
        for (int i = 0; i < 64; i++) issue(32'h100 + 32'(i));
        check("full_no_ovf", 64'(err_tag_overflow), 64'd0);
        issue_valid = 1'b1;
        issue_nonce = 32'h200;
        send_hash(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        issue_valid = 1'b0;
        check("full_push_pop_no_ovf", 64'(err_tag_overflow), 64'd0);
        issue(32'h201);
        check("full_ovf_flag", 64'(err_tag_overflow), 64'd1);

        // Reset mid-stream with three golden entries queued
        for (int i = 0; i < 3; i++) send_hash(64'h1, 64'h100, 1'b1);
        tick();
        tick();
        check("midrst_pre_valid", 64'(gold_valid), 64'd1);
        check("midrst_pre_nonce", 64'(gold_nonce), 64'h101);
        check_counts("midrst_pre");
        #3 rst = 1'b1;
        #1;
        check("midrst_async_valid", 64'(gold_valid), 64'd0);
        check("midrst_async_nonce", 64'(gold_nonce), 64'd0);
        exp_hash_cnt = '0;
        exp_gold_cnt = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("midrst_flags", {61'd0, err_tag_overflow, err_tag_underflow, err_gold_drop}, 64'd0);
        check("midrst_valid", 64'(gold_valid), 64'd0);
        check_counts("midrst");
        send_hash(64'h1, 64'h100, 1'b0);
        tick();
        tick();
        check("midrst_tags_cleared", 64'(err_tag_underflow), 64'd1);
        check("midrst_no_gold", 64'(gold_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/keccak_result_checker.md
Name: keccak_result_checker

Overview:
- Consumer end of the Keccak-800 hasher output interface, placed after the hasher in each miner core.
- The hasher issues one hash per `read` strobe and returns it, with no backpressure, on its `write` strobe a fixed number of cycles later.
- This block re-associates each returned hash with the nonce that produced it, using an in-order tag queue, and compares the hash against the difficulty target.
- Winning ("golden") nonces are queued in an output FIFO behind a valid/ready handshake for the host/UART side.

Parameters:
- NONCE_W, 32: width of the nonce carried alongside each issued hash.
- TAG_DEPTH, 64: tag queue entries. Power of two. Must be at least the hasher LATENCY divided by THROUGHPUT, plus 2.
- OUT_DEPTH, 4: golden-nonce FIFO entries. Power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  pulses in the same cycle the hasher `read` is asserted.
- issue_nonce  in  NONCE_W  nonce for the hash being issued.
- hash_valid  in  1  hasher `write` strobe.
- hash_in  in  256  hasher `out`; valid in the cycle hash_valid is high.
- target  in  64  difficulty target; sampled in the hash_valid cycle.
- gold_valid  out  1  golden-nonce FIFO not empty.
- gold_ready  in  1  consumer accepts the head entry.
- gold_nonce  out  NONCE_W  nonce at the FIFO head.
- gold_hash_hi  out  64  hash_in[255:192] of the FIFO head.
- err_tag_overflow  out  1  sticky flag: issue arrived while the tag queue was full.
- err_tag_underflow  out  1  sticky flag: hash arrived while the tag queue was empty.
- err_gold_drop  out  1  sticky flag: golden result lost because the FIFO was full.
- hash_count  out  32  hashes checked (see Optional Feature).
- gold_count  out  32  golden results found (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - Both queues empty.
  - All outputs 0; err flags 0; counters 0; compare stage invalid.
- Tag queue: circular buffer with read/write pointers one bit wider than log2(TAG_DEPTH). Full and empty are derived from the MSB/pointer comparison.
  - Push on issue_valid.
    - If the queue is full and there is no pop this cycle: discard the push and set err_tag_overflow.
    - If the queue is full and there is a pop this cycle: accept the push.
  - Pop on hash_valid.
    - If the queue is empty: set err_tag_underflow and discard the hash.
    - A same-cycle push into an empty queue is still recorded, but the hash does not use it.
  - Pointers wrap modulo 2*TAG_DEPTH.
- Compare stage: one register stage.
  - Cycle N, hash_valid with a successful pop: register the nonce, hash_in[255:192], and golden = (hash_in[255:192] < target). The comparison is unsigned and strict.
  - Cycle N+1: if golden, push {nonce, hash_hi} into the output FIFO.
  - Latency from hash_valid to gold_valid (FIFO previously empty) is 2 cycles.
- Output FIFO: first-word-fall-through.
  - gold_valid = !empty; data shows the head entry.
  - Pop when gold_valid && gold_ready.
  - Push while full with a same-cycle pop: accepted.
  - Push while full without a pop: dropped, and err_gold_drop set.
  - gold_ready while empty: ignored.
- Sticky flags clear only on rst.
- Reset mid-operation: in-flight compare result and all queued tags/results are discarded. No output glitch after rst deasserts.

Optional Feature:
- Macro KECCAK_CHECK_STATS_EN.
- Defined:
  - hash_count increments on every successful tag pop.
  - gold_count increments on every golden compare.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: no counter registers are built; hash_count and gold_count are tied to 0.

Test Plan:
- Nonce association: issue nonces 0x10, 0x11, 0x12; return hashes 26 cycles later with hash_hi 0xFFFF.., 0x0000_0000_0000_0005, 0xFFFF..; target 0x100. Required: exactly one gold entry, nonce 0x11, hash_hi 0x5, gold_valid 2 cycles after that hash_valid.
- Compare boundary: hash_hi == target (0x100) → not golden. hash_hi = 0xFF → golden.
- Backpressure: gold_ready=0, 5 golden hashes, OUT_DEPTH 4. Required: 4 entries held in order, err_gold_drop=1. Then gold_ready=1 drains the 4 nonces in issue order, and gold_valid falls after the 4th.
- Tag queue full: 64 issues with no hashes, then a 65th issue together with a hash_valid. Required: no overflow flag. A 66th issue without hash_valid sets err_tag_overflow.
- Underflow: hash_valid with the queue empty → err_tag_underflow=1 and no gold entry. With STATS_EN, hash_count stays 0.
- Reset mid-stream: assert rst with 3 queued golden entries. Required: gold_valid=0 immediately (async), and all flags and counters read 0 after release.
